ps2_rx_scancode: RTL and testbench
==================================

# ps2_rx_scancode

PS/2 keyboard receiver that sits directly upstream of the seven-segment scancode display. It synchronises and filters the raw `ps2_clk` and `ps2_data` pins, and deframes 11-bit device-to-host frames. It then decodes the E0 (extended) and F0 (break) prefixes, presents each make code on `scancode`, and issues a one-cycle `keyPressed` strobe. The display and LED timer consume those two signals unchanged.

## Interface
- CLK_HZ, 100_000_000, system clock frequency; documentation only.
- FILTER_LEN, 8, number of consecutive equal samples required before the filtered PS/2 clock or data changes.
- TIMEOUT_CYCLES, 200_000, idle clk cycles (2 ms at 100 MHz) allowed between PS/2 falling edges inside a frame.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- ps2_clk  in  1  raw PS/2 clock pin; asynchronous.
- ps2_data  in  1  raw PS/2 data pin; asynchronous.
- scancode  out  8  last make code received, excluding the prefix byte.
- keyPressed  out  1  one-cycle strobe when `scancode` is updated by a make code.
- keyReleased  out  1  one-cycle strobe when a break sequence (F0 xx or E0 F0 xx) completes.
- extended  out  1  set if the last completed make or break carried an E0 prefix.
- frame_err  out  1  one-cycle strobe on a parity, start, stop or timeout error.

## Operation
- **Input path.** Two-flop synchroniser on each pin, followed by a FILTER_LEN-deep glitch filter. The filtered level changes only when all FILTER_LEN samples agree. A falling edge of the filtered clock produces a one-cycle `fall` pulse. Data is sampled from the filtered data signal in the same cycle.
- **Frame FSM.** States are IDLE, DATA, PARITY and STOP, with one bit consumed per `fall` pulse.
  - IDLE: if data = 0 (start bit), clear the bit counter and go to DATA. If data = 1, assert `frame_err` and stay in IDLE.
  - DATA: shift the bit in LSB-first. After 8 bits, go to PARITY.
  - PARITY: check that the XOR of the 8 data bits and the parity bit equals 1 (odd parity). Record pass/fail and go to STOP.
  - STOP: data must be 1 and parity must have passed. If both hold, the byte is valid and is handed to the decoder. Otherwise assert `frame_err` and discard the byte. Return to IDLE in either case.
- **Timeout.** A counter runs in every non-IDLE state and reloads on each `fall`. When it reaches TIMEOUT_CYCLES, the FSM forces IDLE, asserts `frame_err` and clears the prefix flags.
- **Decoder.** Holds two flags, `ext_pend` and `brk_pend`.
  - Valid byte E0: set `ext_pend`.
  - Valid byte F0: set `brk_pend`.
  - Any other valid byte with `brk_pend` = 1: strobe `keyReleased`, set `extended` = `ext_pend`, and leave `scancode` unchanged.
  - Any other valid byte with `brk_pend` = 0: set `scancode` to the byte, set `extended` = `ext_pend`, and strobe `keyPressed`.
  - Both flags clear after any non-prefix byte and on any error.
- **Repeats.** Typematic repeats of the same make code strobe `keyPressed` each time.
- **Bidirectional use.** This block is receive-only. It never drives the PS/2 pins.

## Timing
- **Reset values.** `scancode` = 0x00, `keyPressed` = `keyReleased` = `frame_err` = 0, `extended` = 0. The FSM is in IDLE, the flags are clear, and the filter and synchroniser registers are set to 1 (bus idle).
- **Reset priority.** `rst` has priority over all events. Reset asserted mid-frame abandons the partial byte with no strobes.
- **Latency.** An edge on the raw pin reaches `fall` after 2 sync cycles plus FILTER_LEN filter cycles. The strobes and `scancode` update one cycle after the `fall` that samples the stop bit, giving 11 clk cycles from the raw stop-bit falling edge at default parameters.
- **Strobe width.** All strobes are exactly one clk cycle wide.
  - `keyPressed`, `keyReleased` and `frame_err` are mutually exclusive within a cycle.
  - `scancode` and `extended` are stable in the same cycle as their strobe.
- **Glitch rejection.** Pulses on `ps2_clk` shorter than FILTER_LEN cycles produce no `fall`.
- **Timeout window.** A timeout fires exactly TIMEOUT_CYCLES cycles after the last `fall` inside a frame. A `fall` arriving on the same cycle as the timeout is ignored.

## Test plan
- **Make code.** Frame 0x1C (parity 0, stop 1) at a 12.5 kHz PS/2 clock → one `keyPressed` pulse, `scancode` = 0x1C, `extended` = 0, 11 cycles after the stop-bit edge; no other strobes.
- **Break code.** Frames F0 then 1C after the make code → one `keyReleased` pulse, `scancode` still 0x1C, no `keyPressed`.
- **Extended key.** Frames E0 75 then E0 F0 75 → `keyPressed` with `scancode` = 0x75 and `extended` = 1, then `keyReleased` with `extended` = 1; E0 alone produces no strobe.
- **Framing errors.** 0x1C with parity 1, then 0x1C with stop 0 → two `frame_err` pulses, no `keyPressed`, `scancode` unchanged. A following valid 0x32 then decodes correctly.
- **Timeout.** Start bit plus 4 data bits, then the bus is held idle → `frame_err` exactly 200_000 cycles after the last edge. A subsequent 0x32 frame gives `keyPressed` with `scancode` = 0x32.
- **Glitch and reset.** A 5-cycle glitch on `ps2_clk` during DATA produces no bit shift. `rst` pulsed after 6 data bits clears all outputs to their reset values; the next full 0x1C frame decodes normally.

Source files
------------

// File: rtl/ps2_rx_scancode.sv
// PS/2 device-to-host receiver: pin synchronise/filter, 11-bit deframing,
// E0/F0 prefix decode into scancode + keyPressed/keyReleased strobes.

module ps2_rx_pin_filt #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic filt
);
  logic [1:0]            sync;
  logic [FILTER_LEN-2:0] hist;
  logic [FILTER_LEN-1:0] window;

  // Newest synchronised sample is part of the window so the filter costs FILTER_LEN cycles, not one more.
  assign window = {hist, sync[1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= '1;
      hist <= '1;
      filt <= 1'b1;
    end else begin
      sync <= {sync[0], raw};
      hist <= window[FILTER_LEN-2:0];
      if (&window)       filt <= 1'b1;
      else if (~|window) filt <= 1'b0;
    end
  end
endmodule

module ps2_rx_scancode #(
  parameter int CLK_HZ         = 100_000_000,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 200_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] scancode,
  output logic       keyPressed,
  output logic       keyReleased,
  output logic       extended,
  output logic       frame_err
);
  localparam int         NUM_PINS = 2;
  localparam int         TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0] CODE_EXT = 8'hE0;
  localparam logic [7:0] CODE_BRK = 8'hF0;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  typedef struct packed {
    logic       vld;
    logic [7:0] data;
  } byte_t;

  if (FILTER_LEN < 2 || TIMEOUT_CYCLES < 2 || CLK_HZ < 1) begin : g_param_chk
    $error("ps2_rx_scancode: unsupported parameter values");
  end

  logic [NUM_PINS-1:0] pin_raw;
  logic [NUM_PINS-1:0] pin_filt;

  assign pin_raw = {ps2_data, ps2_clk};

  for (genvar i = 0; i < NUM_PINS; i++) begin : g_pin
    ps2_rx_pin_filt #(.FILTER_LEN(FILTER_LEN)) u_filt (
      .clk  (clk),
      .rst  (rst),
      .raw  (pin_raw[i]),
      .filt (pin_filt[i])
    );
  end

  logic clk_q;
  logic fall;
  logic din;

  assign din  = pin_filt[1];
  assign fall = clk_q & ~pin_filt[0];

  always_ff @(posedge clk) begin
    if (rst) clk_q <= 1'b1;
    else     clk_q <= pin_filt[0];
  end

  state_t          state, state_nx;
  logic [7:0]      shreg;
  logic [2:0]      bitcnt;
  logic            par_ok;
  logic [TW-1:0]   tcnt;
  logic            timeout;
  byte_t           rx_byte;
  logic            err;

  // Timeout wins over a coincident fall; the frame is abandoned either way.
  assign timeout = (state != IDLE) && (tcnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (timeout) begin
      state_nx = IDLE;
    end else if (fall) begin
      unique case (state)
        IDLE:    if (!din) state_nx = DATA;
        DATA:    if (bitcnt == 3'd7) state_nx = PARITY;
        PARITY:  state_nx = STOP;
        STOP:    state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_comb begin
    rx_byte = '{vld: 1'b0, data: shreg};
    err     = 1'b0;
    if (timeout) begin
      err = 1'b1;
    end else if (fall) begin
      case (state)
        IDLE: err = din;
        STOP: begin
          rx_byte.vld = din & par_ok;
          err         = ~(din & par_ok);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg  <= '0;
      bitcnt <= '0;
      par_ok <= 1'b0;
      tcnt   <= '0;
    end else begin
      if (state == IDLE || fall) tcnt <= '0;
      else                       tcnt <= tcnt + TW'(1);
      if (fall && !timeout) begin
        case (state)
          IDLE:   bitcnt <= '0;
          DATA: begin
            shreg  <= {din, shreg[7:1]};
            bitcnt <= bitcnt + 3'd1;
          end
          PARITY: par_ok <= ^{shreg, din};
          default: ;
        endcase
      end
    end
  end

  logic ext_pend;
  logic brk_pend;

  always_ff @(posedge clk) begin
    if (rst) begin
      scancode    <= '0;
      keyPressed  <= 1'b0;
      keyReleased <= 1'b0;
      extended    <= 1'b0;
      frame_err   <= 1'b0;
      ext_pend    <= 1'b0;
      brk_pend    <= 1'b0;
    end else begin
      keyPressed  <= 1'b0;
      keyReleased <= 1'b0;
      frame_err   <= err;
      if (err) begin
        ext_pend <= 1'b0;
        brk_pend <= 1'b0;
      end else if (rx_byte.vld) begin
        if (rx_byte.data == CODE_EXT) begin
          ext_pend <= 1'b1;
        end else if (rx_byte.data == CODE_BRK) begin
          brk_pend <= 1'b1;
        end else begin
          extended <= ext_pend;
          ext_pend <= 1'b0;
          brk_pend <= 1'b0;
          if (brk_pend) begin
            keyReleased <= 1'b1;
          end else begin
            keyPressed <= 1'b1;
            scancode   <= rx_byte.data;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_ps2_rx_scancode.sv
// Directed + randomized frames against a byte-level model of the PS/2 decoder.

module tb_ps2_rx_scancode;
  localparam int FL  = 8;
  localparam int TMO = 300;
  localparam int LAT = 2 + FL + 1;
  localparam int HP  = 20;
  localparam int GAP = 40;

  logic       clk = 1'b0;
  logic       rst;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] scancode;
  logic       keyPressed, keyReleased, extended, frame_err;

  ps2_rx_scancode #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TMO)) dut (
    .clk         (clk),
    .rst         (rst),
    .ps2_clk     (ps2_clk),
    .ps2_data    (ps2_data),
    .scancode    (scancode),
    .keyPressed  (keyPressed),
    .keyReleased (keyReleased),
    .extended    (extended),
    .frame_err   (frame_err)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // kind: 1 press, 2 release, 3 frame error
  typedef struct {
    int         kind;
    logic [7:0] code;
    logic       ext;
    longint     cyc;
  } ev_t;
  ev_t evq[$];

  always @(negedge clk) begin
    if (!rst) begin
      if (keyPressed)  evq.push_back(ev_t'{1, scancode, extended, cyc});
      if (keyReleased) evq.push_back(ev_t'{2, scancode, extended, cyc});
      if (frame_err)   evq.push_back(ev_t'{3, scancode, extended, cyc});
    end
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Byte-level decoder model
  logic [7:0] m_code = 8'h00;
  bit         m_ext = 0;
  bit         m_brk = 0;

  task automatic model(input bit ok, input logic [7:0] b, output int kind, output logic ext);
    kind = 0;
    ext  = 1'b0;
    if (!ok) begin
      kind = 3; m_ext = 0; m_brk = 0;
    end else if (b == 8'hE0) begin
      m_ext = 1;
    end else if (b == 8'hF0) begin
      m_brk = 1;
    end else begin
      kind = m_brk ? 2 : 1;
      if (!m_brk) m_code = b;
      ext = m_ext;
      m_ext = 0; m_brk = 0;
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit stop,
                            input int nbits, input int glitch_bit, output longint lf);
    logic [10:0] bits;
    bits = {stop, (~^b) ^ bad_par, b, 1'b0};
    lf = 0;
    for (int i = 0; i < nbits; i++) begin
      if (i == glitch_bit) begin
        wait_cyc(12);
        ps2_clk = 1'b0;
        wait_cyc(5);
        ps2_clk = 1'b1;
        wait_cyc(12);
      end
      wait_cyc(HP / 2);
      ps2_data = bits[i];
      wait_cyc(HP / 2);
      ps2_clk = 1'b0;
      lf = cyc;
      wait_cyc(HP);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    wait_cyc(GAP);
  endtask

  task automatic expect_ev(input string tag, input int kind, input logic [7:0] code,
                           input logic ext, input longint cyc_exp);
    ev_t ev;
    chk({tag, "/n_events"}, 64'(evq.size()), (kind == 0) ? 64'd0 : 64'd1);
    if (kind != 0 && evq.size() > 0) begin
      ev = evq.pop_front();
      chk({tag, "/kind"}, 64'(ev.kind), 64'(kind));
      chk({tag, "/latency"}, 64'(ev.cyc), 64'(cyc_exp));
      if (kind != 3) begin
        chk({tag, "/code"}, 64'(ev.code), 64'(code));
        chk({tag, "/ext"}, 64'(ev.ext), 64'(ext));
      end
    end
    evq.delete();
  endtask

  task automatic frame_chk(input string tag, input logic [7:0] b, input bit bad_par,
                           input bit stop, input int glitch_bit);
    longint lf;
    int     k;
    logic   e;
    send_frame(b, bad_par, stop, 11, glitch_bit, lf);
    model(!bad_par && stop, b, k, e);
    expect_ev(tag, k, m_code, e, lf + LAT);
    chk({tag, "/scancode"}, 64'(scancode), 64'(m_code));
  endtask

  initial begin
    longint     lf;
    int         k, r;
    logic       e;
    logic [7:0] b, prev;

    rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1;
    wait_cyc(5);
    chk("reset/scancode",    64'(scancode),    64'h00);
    chk("reset/keyPressed",  64'(keyPressed),  64'h0);
    chk("reset/keyReleased", 64'(keyReleased), 64'h0);
    chk("reset/extended",    64'(extended),    64'h0);
    chk("reset/frame_err",   64'(frame_err),   64'h0);
    rst = 1'b0;
    wait_cyc(20);

    frame_chk("make_1c", 8'h1C, 0, 1, -1);
    frame_chk("brk_f0",  8'hF0, 0, 1, -1);
    frame_chk("brk_1c",  8'h1C, 0, 1, -1);

    frame_chk("ext_e0",     8'hE0, 0, 1, -1);
    frame_chk("ext_make75", 8'h75, 0, 1, -1);
    frame_chk("ext_e0b",    8'hE0, 0, 1, -1);
    frame_chk("ext_f0",     8'hF0, 0, 1, -1);
    frame_chk("ext_brk75",  8'h75, 0, 1, -1);

    frame_chk("err_parity", 8'h1C, 1, 1, -1);
    frame_chk("err_stop",   8'h1C, 0, 0, -1);
    frame_chk("after_err",  8'h32, 0, 1, -1);

    // Pending E0 must be dropped by the timeout
    frame_chk("tmo_e0", 8'hE0, 0, 1, -1);
    send_frame(8'h5A, 0, 1, 5, -1, lf);
    wait_cyc(TMO + 40);
    model(0, 8'h00, k, e);
    expect_ev("timeout", k, m_code, e, lf + LAT + TMO);
    frame_chk("after_tmo", 8'h32, 0, 1, -1);

    // Lone clock pulse with data high: bad start bit
    wait_cyc(HP);
    ps2_clk = 1'b0;
    lf = cyc;
    wait_cyc(HP);
    ps2_clk = 1'b1;
    wait_cyc(GAP);
    model(0, 8'h00, k, e);
    expect_ev("start_err", k, m_code, e, lf + LAT);

    frame_chk("glitch", 8'h1C, 0, 1, 3);
    frame_chk("pre_rst", 8'h4B, 0, 1, -1);

    send_frame(8'h6B, 0, 1, 7, -1, lf);
    rst = 1'b1;
    wait_cyc(3);
    m_code = 8'h00; m_ext = 0; m_brk = 0;
    chk("midrst/scancode", 64'(scancode), 64'h00);
    chk("midrst/extended", 64'(extended), 64'h0);
    chk("midrst/strobes",  64'({keyPressed, keyReleased, frame_err}), 64'h0);
    rst = 1'b0;
    wait_cyc(20);
    expect_ev("midrst_quiet", 0, m_code, 1'b0, 0);
    frame_chk("post_rst", 8'h1C, 0, 1, -1);

    prev = 8'h1C;
    for (int i = 0; i < 14; i++) begin
      r = $urandom_range(0, 9);
      b = 8'($urandom);
      if (r == 0)      b = 8'hE0;
      else if (r == 1) b = 8'hF0;
      else if (r == 2) b = prev;
      frame_chk("rand", b, r == 3, r != 4, -1);
      prev = b;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
